// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl -- execute-stage sequencing controller.
// Holds EX across the load/store memory handshake and multi-cycle mul/div
// operations, injects a single bubble on a load-use hazard, and flushes
// younger instructions after a branch/jump redirect resolved in EX.
// Control outputs are combinational from the registered state plus the
// current inputs; they are forced low while rst_n is asserted so that an
// outstanding request is abandoned the moment reset arrives.

module ex_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic        ex_mdu,
    input  logic        ex_redirect,
    input  logic        mem_ack,
    input  logic        mdu_done,
    output logic        mem_req,
    output logic        mdu_start,
    output logic        stall,
    output logic        ex_hold,
    output logic        clear,
    output logic        mem_err,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MDU_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    // Last wait-counter value before the memory request is abandoned.
    localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);
    // Flush counter value loaded when the redirect cycle hands over to FLUSH.
    localparam logic [2:0]  FL_INIT = 3'(FLUSH_CYCLES - 1);

    // Saturating 32-bit increment for the stall statistic.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        logic [31:0] res;
        if (v == 32'hFFFF_FFFF) begin
            res = v;
        end else begin
            res = v + 32'd1;
        end
        return res;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_to_cnt;
    logic [15:0] w_to_cnt_nxt;
    logic [2:0]  r_fl_cnt;
    logic [2:0]  w_fl_cnt_nxt;
    logic        r_mem_err;
    logic        w_mem_err_set;
    logic [31:0] r_stall_cnt;

    logic        w_mem_op;
    logic        w_mdu_op;
    logic        w_redir;
    logic        w_rs_match;
    logic        w_mem_req;
    logic        w_mdu_start;
    logic        w_stall;
    logic        w_ex_hold;
    logic        w_clear;

    // A mem op wins over mdu when both flags are set on one instruction.
    assign w_mem_op = ex_valid & (ex_load | ex_store);
    assign w_mdu_op = ex_valid & ex_mdu & ~(ex_load | ex_store);
    assign w_redir  = ex_valid & ex_redirect;

    // ID consumer reads the register the EX load writes (x0 never hazards).
    assign w_rs_match = id_valid & (ex_rd != 5'd0) &
                        ((id_use_rs1 & (id_rs1 == ex_rd)) |
                         (id_use_rs2 & (id_rs2 == ex_rd)));

    // Next-state, counter updates and pipeline controls for the current state.
    always_comb begin
        w_state_nxt   = r_state;
        w_to_cnt_nxt  = r_to_cnt;
        w_fl_cnt_nxt  = r_fl_cnt;
        w_mem_err_set = 1'b0;
        w_mem_req     = 1'b0;
        w_mdu_start   = 1'b0;
        w_stall       = 1'b0;
        w_ex_hold     = 1'b0;
        w_clear       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_op) begin
                    w_mem_req = 1'b1;
                    if (mem_ack) begin
                        // Load completes at once: the load retires, bubble on hazard.
                        if (ex_load && w_rs_match) begin
                            w_stall = 1'b1;
                            w_clear = 1'b1;
                        end else begin
                            w_stall = 1'b0;
                        end
                    end else begin
                        w_stall      = 1'b1;
                        w_ex_hold    = 1'b1;
                        w_state_nxt  = ST_MEM_WAIT;
                        w_to_cnt_nxt = 16'd0;
                    end
                end else if (w_mdu_op) begin
                    w_mdu_start = 1'b1;
                    w_stall     = 1'b1;
                    w_ex_hold   = 1'b1;
                    w_state_nxt = ST_MDU_WAIT;
                end else if (w_redir) begin
                    w_clear = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt  = ST_FLUSH;
                        w_fl_cnt_nxt = FL_INIT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MEM_WAIT: begin
                w_mem_req = 1'b1;
                if (mem_ack) begin
                    w_state_nxt  = ST_IDLE;
                    w_to_cnt_nxt = 16'd0;
                    if (ex_load && w_rs_match) begin
                        w_stall = 1'b1;
                        w_clear = 1'b1;
                    end else begin
                        w_stall = 1'b0;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    // Abandon the access: the bubble replaces the stuck
                    // instruction, so ID/EX is not held this cycle.
                    w_mem_err_set = 1'b1;
                    w_stall       = 1'b1;
                    w_clear       = 1'b1;
                    w_state_nxt   = ST_IDLE;
                    w_to_cnt_nxt  = 16'd0;
                end else begin
                    w_stall      = 1'b1;
                    w_ex_hold    = 1'b1;
                    w_to_cnt_nxt = r_to_cnt + 16'd1;
                end
            end
            ST_MDU_WAIT: begin
                if (mdu_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_stall   = 1'b1;
                    w_ex_hold = 1'b1;
                end
            end
            ST_FLUSH: begin
                // Squashed instructions: every ex_* input is ignored here.
                w_clear = 1'b1;
                if (r_fl_cnt <= 3'd1) begin
                    w_state_nxt  = ST_IDLE;
                    w_fl_cnt_nxt = 3'd0;
                end else begin
                    w_fl_cnt_nxt = r_fl_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_to_cnt_nxt = 16'd0;
                w_fl_cnt_nxt = 3'd0;
            end
        endcase
    end

    // State register and the memory-timeout / flush counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_to_cnt <= 16'd0;
            r_fl_cnt <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_to_cnt <= w_to_cnt_nxt;
            r_fl_cnt <= w_fl_cnt_nxt;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_err <= 1'b0;
        end else if (w_mem_err_set) begin
            r_mem_err <= 1'b1;
        end else begin
            r_mem_err <= r_mem_err;
        end
    end

    // Saturating count of cycles in which the front end is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    // Combinational controls are blanked while reset is asserted.
    assign mem_req   = w_mem_req   & rst_n;
    assign mdu_start = w_mdu_start & rst_n;
    assign stall     = w_stall     & rst_n;
    assign ex_hold   = w_ex_hold   & rst_n;
    assign clear     = w_clear     & rst_n;
    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Execute-stage sequencing controller for the in-order RISC-V pipeline.
- Decides when the EX stage may advance:
  - holds EX during the load/store memory handshake and during multi-cycle mul/div operations;
  - inserts a bubble on a load-use hazard;
  - flushes younger instructions on a branch/jump redirect.
- Drives the pipeline's stall/clear controls and the start/request strobes of the multi-cycle resources it shares with EX.

Parameters:
- FLUSH_CYCLES, 2: number of cycles clear is asserted after a redirect (range 1..7).
- MEM_TIMEOUT, 256: wait cycles in MEM_WAIT before the request is abandoned (range 1..65535).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID holds a valid instruction.
- id_rs1  input  5  ID source register 1.
- id_rs2  input  5  ID source register 2.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2.
- ex_valid  input  1  EX holds a valid instruction.
- ex_rd  input  5  EX destination register.
- ex_load  input  1  EX instruction is a load (io_ops.load_op).
- ex_store  input  1  EX instruction is a store (io_ops.store_op).
- ex_mdu  input  1  EX instruction is mul/div.
- ex_redirect  input  1  branch taken or jump resolved in EX (bj unit).
- mem_ack  input  1  memory accepted/completed the request.
- mdu_done  input  1  mul/div result valid.
- mem_req  output  1  memory request.
- mdu_start  output  1  one-cycle start pulse to the mul/div unit.
- stall  output  1  hold PC and IF/ID.
- ex_hold  output  1  hold the ID/EX register; EX does not retire.
- clear  output  1  bubble into ID/EX (and IF/ID during flush).
- mem_err  output  1  sticky memory-timeout flag.
- stall_cnt  output  32  saturating count of cycles with stall=1.

Behaviour:
- Reset:
  - Asynchronous, active-low: clock is clk, reset is rst_n, reset asserts asynchronously and releases synchronously to clk.
  - Reset value of every output, including the state register, counters and mem_err, is 0; state resets to IDLE.
  - Reset mid-operation abandons any outstanding request immediately; mem_req and mdu_start drop asynchronously.
- States: IDLE, MEM_WAIT, MDU_WAIT, FLUSH. Outputs are combinational from state plus inputs; state and counters are registered.
- IDLE, memory op (ex_valid & (ex_load | ex_store)):
  - mem_req=1.
  - If mem_ack: no hold, stay in IDLE.
  - Otherwise: stall=1, ex_hold=1, next state MEM_WAIT, timeout counter cleared.
- MEM_WAIT:
  - mem_req=1.
  - Without ack: stall=1, ex_hold=1, and the counter increments.
  - On mem_ack: stall and ex_hold are 0 in that cycle; next state IDLE.
  - When the counter reaches MEM_TIMEOUT-1 without ack: mem_err is set (sticky until reset), clear=1 for that cycle, mem_req drops next cycle, next state IDLE.
- Load-use hazard:
  - Condition: in the cycle a load completes (mem_ack with ex_load), ex_rd != 0, id_valid, and ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Response: stall=1, clear=1, ex_hold=0. The load advances; a single bubble enters EX.
  - Stores never cause a load-use bubble.
- IDLE, mul/div op (ex_valid & ex_mdu):
  - mdu_start=1 for exactly one cycle.
  - stall=1, ex_hold=1, next state MDU_WAIT.
- MDU_WAIT:
  - stall=1, ex_hold=1 until mdu_done.
  - In the done cycle stall and ex_hold are 0; next state IDLE.
  - mdu_done in the start cycle is ignored.
- Redirect:
  - Condition: IDLE & ex_valid & ex_redirect with no memory/mdu op.
  - clear=1 in that cycle.
  - If FLUSH_CYCLES>1: next state FLUSH with counter FLUSH_CYCLES-1.
- FLUSH:
  - clear=1, stall=0; counter decrements; state returns to IDLE after the counter hits 1.
  - All ex_* inputs are ignored (squashed instructions).
- Priority within one cycle: reset > memory/mdu hold > redirect > load-use.
  - An instruction flagged both mdu and load is treated as a memory op.
- stall_cnt increments each cycle stall=1 and saturates at 32'hFFFFFFFF.

Test Plan:
- Reset, then a load in EX with mem_ack high in the same cycle, ex_rd=5, ID reads x3 -> stall=0, clear=0, stays in IDLE, stall_cnt=0.
- Load ex_rd=5, mem_ack arrives 3 cycles late, ID id_rs2=5 with id_use_rs2=1:
  - stall=1, ex_hold=1 for 3 cycles;
  - ack cycle: stall=1, clear=1, ex_hold=0;
  - stall_cnt=4.
- Load with ex_rd=0 and a matching ID rs1=0 -> no bubble.
- ex_mdu=1, mdu_done 10 cycles after start:
  - mdu_start pulses once;
  - stall=1 for 10 cycles, 0 in the done cycle;
  - stall_cnt=10.
- ex_redirect=1 with FLUSH_CYCLES=2 -> clear=1 for exactly 2 consecutive cycles; an ex_load during the FLUSH cycle produces no mem_req.
- Store with mem_ack never asserted, MEM_TIMEOUT=4:
  - mem_err rises after 4 wait cycles, clear pulses once, state returns to IDLE;
  - rst_n pulsed low mid-wait clears mem_err, mem_req and stall_cnt immediately.
